// File: rtl/spi_master_multi.sv
// SPI master with a configurable word width and chip-select count, per-transfer CPOL/CPHA and bit order,
// and chip-select hold across words so that multi-word flash commands run under one continuous CS.
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 2,
  parameter int CLK_DIV = 4,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              hold_cs,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_clk,
  output logic              spi_out,
  input  logic              spi_in,
  output logic [NUM_CS-1:0] spi_cs_n
);
  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam int EW    = $clog2(2 * DATA_W) + 1;
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(CLK_DIV - 1);
  localparam logic [EW-1:0]    LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, TAIL, DESEL, HELD, REL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]       edge_q, edge_d;
  logic [DATA_W-1:0]   sh_q, sh_d, rs_q, rs_d, rx_q, rx_d;
  logic [CS_W-1:0]     sel_q, sel_d;
  logic                hold_q, hold_d, cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic                spi_clk_q, spi_clk_d, spi_out_q, spi_out_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                tick, lead, load, cs_on;

  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Next-state, divider, shift and pad logic.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    sh_d      = sh_q;
    rs_d      = rs_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    spi_clk_d = spi_clk_q;
    spi_out_d = spi_out_q;
    done_d    = 1'b0;
    rx_d      = rx_q;
    lead      = 1'b0;
    load      = 1'b0;
    tick      = (cnt_q == {CNT_W{1'b0}});
    case (state_q)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          spi_clk_d = cpol;
          state_d   = SETUP;
        end else begin
          spi_clk_d = cpol_q;
        end
      end
      SETUP: begin
        if (tick) begin
          edge_d  = {EW{1'b0}};
          state_d = XFER;
        end else begin
          state_d = SETUP;
        end
      end
      XFER: begin
        if (tick) begin
          spi_clk_d = ~spi_clk_q;
          edge_d    = edge_q + EW'(1);
          lead      = ~edge_q[0];
          // The final trailing edge in CPHA=0 has no next bit, so MOSI keeps the last one.
          if (lead ^ cpha_q) begin
            rs_d = rx_shift(rs_q, spi_in, lsb_q);
          end else if (edge_q != LAST_EDGE) begin
            spi_out_d = out_bit(sh_q, lsb_q);
            sh_d      = tx_shift(sh_q, lsb_q);
          end else begin
            spi_out_d = spi_out_q;
          end
          state_d = (edge_q == LAST_EDGE) ? TAIL : XFER;
        end else begin
          state_d = XFER;
        end
      end
      TAIL: begin
        if (tick && hold_q) begin
          state_d = HELD;
          done_d  = 1'b1;
          rx_d    = rs_q;
        end else if (tick) begin
          state_d = DESEL;
        end else begin
          state_d = TAIL;
        end
      end
      DESEL: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rx_d    = rs_q;
        end else begin
          state_d = DESEL;
        end
      end
      HELD: begin
        // A new target or clock polarity needs a deselect gap before the next word.
        if (start && ((cs_sel != sel_q) || (cpol != cpol_q))) begin
          load      = 1'b1;
          spi_clk_d = cpol;
          state_d   = REL;
        end else if (start) begin
          load    = 1'b1;
          edge_d  = {EW{1'b0}};
          state_d = XFER;
        end else begin
          state_d = HELD;
        end
      end
      REL: begin
        state_d = tick ? SETUP : REL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      sel_d  = cs_sel;
      hold_d = hold_cs;
      cpol_d = cpol;
      cpha_d = cpha;
      lsb_d  = lsb_first;
      rs_d   = {DATA_W{1'b0}};
      if (!cpha) begin
        spi_out_d = out_bit(tx_data, lsb_first);
        sh_d      = tx_shift(tx_data, lsb_first);
      end else begin
        sh_d = tx_data;
      end
    end else begin
      sel_d = sel_q;
    end

    cnt_d  = (tick || (state_d != state_q)) ? RELOAD : (cnt_q - CNT_W'(1));
    busy_d = !((state_d == IDLE) || (state_d == HELD));
    cs_on  = (state_d == SETUP) || (state_d == XFER) || (state_d == TAIL) || (state_d == HELD);
    for (int i = 0; i < NUM_CS; i++) begin
      cs_n_d[i] = !(cs_on && (sel_d == CS_W'(i)));
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= RELOAD;
      edge_q    <= {EW{1'b0}};
      sh_q      <= {DATA_W{1'b0}};
      rs_q      <= {DATA_W{1'b0}};
      rx_q      <= {DATA_W{1'b0}};
      sel_q     <= {CS_W{1'b0}};
      hold_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      spi_clk_q <= 1'b0;
      spi_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= {NUM_CS{1'b1}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      sh_q      <= sh_d;
      rs_q      <= rs_d;
      rx_q      <= rx_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      spi_clk_q <= spi_clk_d;
      spi_out_q <= spi_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign spi_clk  = spi_clk_q;
  assign spi_out  = spi_out_q;
  assign spi_cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi: a mode-aware SPI slave model supplies MISO and captures MOSI,
// expected words are queued at each start and compared when done pulses.
module tb_spi_master_multi;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [0:0] cs_sel = 1'b0;
  logic       hold_cs = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic       busy, done, spi_clk, spi_out, spi_in;
  logic [7:0] rx_data;
  logic [1:0] spi_cs_n;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  logic       cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0;
  logic [7:0] slv_word = 8'h00, slv_cap, slv_raw;
  int         arm_seq = 0;

  int cs0_high_cnt = 0, cs0_low_cnt = 0, both_low_cnt = 0, gap = 0, last_gap = -1, fall_cnt = 0;
  logic cs1_prev = 1'b1;

  spi_master_multi #(.DATA_W(8), .NUM_CS(2), .CLK_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .hold_cs(hold_cs), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .busy(busy),
    .done(done), .rx_data(rx_data), .spi_clk(spi_clk), .spi_out(spi_out), .spi_in(spi_in),
    .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  function automatic logic slv_bitof(input int i);
    return cur_lsb ? slv_word[i] : slv_word[7-i];
  endfunction

  // Slave model: re-armed per word, shifts on SCK edges according to the current mode.
  initial begin
    int seen = 0;
    int sbit = 8;
    logic ld;
    spi_in  = 1'b0;
    slv_cap = 8'h00;
    slv_raw = 8'h00;
    forever begin
      @(spi_clk or arm_seq);
      if (arm_seq != seen) begin
        seen = arm_seq; sbit = 0; slv_cap = 8'h00; slv_raw = 8'h00;
        if (!cur_cpha) spi_in = slv_bitof(0);
      end else begin
        #1;
        if (sbit < 8) begin
          ld = (spi_clk != cur_cpol);
          if (ld ^ cur_cpha) begin
            slv_raw = {slv_raw[6:0], spi_out};
            slv_cap = cur_lsb ? {spi_out, slv_cap[7:1]} : {slv_cap[6:0], spi_out};
            if (cur_cpha) sbit++;
          end else if (!cur_cpha) begin
            sbit++;
            if (sbit < 8) spi_in = slv_bitof(sbit);
          end else begin
            spi_in = slv_bitof(sbit);
          end
        end
      end
    end
  end

  // Chip-select activity counters, sampled once per clock.
  always @(posedge clk) begin
    if (spi_cs_n[0]) cs0_high_cnt <= cs0_high_cnt + 1;
    else cs0_low_cnt <= cs0_low_cnt + 1;
    if (spi_cs_n == 2'b00) both_low_cnt <= both_low_cnt + 1;
    if (!spi_cs_n[0]) gap <= 0;
    else if (spi_cs_n[1]) gap <= gap + 1;
    if (!spi_cs_n[1] && cs1_prev) last_gap <= gap;
    cs1_prev <= spi_cs_n[1];
  end

  always @(negedge spi_clk) fall_cnt <= fall_cnt + 1;

  task automatic issue(input logic [7:0] tx, input logic sel, input logic hold, input logic pol,
                       input logic pha, input logic lsb, input logic [7:0] sw);
    tx_data = tx; cs_sel = sel; hold_cs = hold; cpol = pol; cpha = pha; lsb_first = lsb;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cur_cpol = pol; cur_cpha = pha; cur_lsb = lsb; slv_word = sw;
    arm_seq++;
    exp_rx.push_back(sw);
    exp_tx.push_back(tx);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 400);
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    #4;
    total++; if (spi_cs_n !== 2'b11) begin bad++; $display("FAIL reset_cs got %b want 11", spi_cs_n); end
    total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL reset_sck got %b want 0", spi_clk); end
    total++; if (spi_out !== 1'b0) begin bad++; $display("FAIL reset_mosi got %b want 0", spi_out); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got %h want 00", rx_data); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    int cyc;
    logic [7:0] e;
    issue(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mode0_busy got %b want 1", busy); end
    wait_done(cyc);
    total++; if (done !== 1'b1 || cyc + 1 != 77) begin bad++; $display("FAIL mode0_latency got %0d want 77", cyc + 1); end
    e = exp_rx.pop_front();
    total++; if (rx_data !== e) begin bad++; $display("FAIL mode0_rx got %h want %h", rx_data, e); end
    e = exp_tx.pop_front();
    total++; if (slv_cap !== e) begin bad++; $display("FAIL mode0_mosi got %h want %h", slv_cap, e); end
    total++; if (slv_raw !== 8'b10100101) begin bad++; $display("FAIL mode0_seq got %b want 10100101", slv_raw); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mode0_busy_end got %b want 0", busy); end
  endtask

  task automatic test_mode3();
    int cyc, low0, fall0;
    logic [7:0] e;
    low0 = cs0_low_cnt; fall0 = fall_cnt;
    issue(8'h9F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    total++; if (spi_clk !== 1'b1) begin bad++; $display("FAIL mode3_idle_sck got %b want 1", spi_clk); end
    wait_done(cyc);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mode3_timeout got %b want 1", done); end
    e = exp_rx.pop_front();
    total++; if (rx_data !== e) begin bad++; $display("FAIL mode3_rx got %h want %h", rx_data, e); end
    e = exp_tx.pop_front();
    total++; if (slv_cap !== e) begin bad++; $display("FAIL mode3_mosi got %h want %h", slv_cap, e); end
    total++; if (cs0_low_cnt - low0 != 72) begin bad++; $display("FAIL mode3_cs_low got %0d want 72", cs0_low_cnt - low0); end
    total++; if (fall_cnt - fall0 != 8) begin bad++; $display("FAIL mode3_falls got %0d want 8", fall_cnt - fall0); end
    total++; if (spi_clk !== 1'b1) begin bad++; $display("FAIL mode3_end_sck got %b want 1", spi_clk); end
  endtask

  task automatic test_lsb_first();
    int cyc;
    logic [7:0] e;
    issue(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
    wait_done(cyc);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL lsb_timeout got %b want 1", done); end
    total++; if (slv_raw !== 8'b10000000) begin bad++; $display("FAIL lsb_seq got %b want 10000000", slv_raw); end
    e = exp_rx.pop_front();
    total++; if (rx_data !== e) begin bad++; $display("FAIL lsb_rx got %h want %h", rx_data, e); end
    e = exp_tx.pop_front();
    total++; if (slv_cap !== e) begin bad++; $display("FAIL lsb_mosi got %h want %h", slv_cap, e); end
  endtask

  task automatic test_flash_id();
    logic [7:0] txs[4] = '{8'h9F, 8'h00, 8'h00, 8'h00};
    logic [7:0] sws[4] = '{8'hFF, 8'h1F, 8'h44, 8'h02};
    int cyc, high0;
    logic [7:0] e;
    high0 = 0;
    for (int i = 0; i < 4; i++) begin
      issue(txs[i], 1'b0, (i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, sws[i]);
      if (i == 0) high0 = cs0_high_cnt;
      wait_done(cyc);
      if (i == 0) begin
        total++; if (cyc + 1 != 73) begin bad++; $display("FAIL flash_held_latency got %0d want 73", cyc + 1); end
      end
      e = exp_rx.pop_front();
      total++; if (rx_data !== e) begin bad++; $display("FAIL flash_rx%0d got %h want %h", i, rx_data, e); end
      e = exp_tx.pop_front();
      total++; if (slv_cap !== e) begin bad++; $display("FAIL flash_mosi%0d got %h want %h", i, slv_cap, e); end
      if (i < 3) begin
        total++; if ({busy, spi_cs_n} !== 3'b010) begin bad++; $display("FAIL flash_held%0d got %b want 010", i, {busy, spi_cs_n}); end
      end
    end
    total++; if (cs0_high_cnt - high0 != 4) begin bad++; $display("FAIL flash_cs_gaps got %0d want 4", cs0_high_cnt - high0); end
  endtask

  task automatic test_ignore_switch();
    int cyc, both0;
    logic [7:0] e;
    both0 = both_low_cnt;
    issue(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81);
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy got %b want 1", busy); end
    tx_data = 8'hFF; cs_sel = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_timeout got %b want 1", done); end
    e = exp_rx.pop_front();
    total++; if (rx_data !== e) begin bad++; $display("FAIL ign_rx got %h want %h", rx_data, e); end
    e = exp_tx.pop_front();
    total++; if (slv_cap !== e) begin bad++; $display("FAIL ign_mosi got %h want %h", slv_cap, e); end
    total++; if (spi_cs_n !== 2'b10) begin bad++; $display("FAIL ign_held_cs got %b want 10", spi_cs_n); end
    issue(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);
    wait_done(cyc);
    e = exp_rx.pop_front();
    total++; if (rx_data !== e) begin bad++; $display("FAIL sw_rx got %h want %h", rx_data, e); end
    e = exp_tx.pop_front();
    total++; if (slv_cap !== e) begin bad++; $display("FAIL sw_mosi got %h want %h", slv_cap, e); end
    total++; if (last_gap != 4) begin bad++; $display("FAIL sw_release_gap got %0d want 4", last_gap); end
    total++; if (both_low_cnt != both0) begin bad++; $display("FAIL sw_both_low got %0d want %0d", both_low_cnt, both0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] txs[3] = '{8'hC6, 8'h3B, 8'hF0};
    logic [7:0] sws[3] = '{8'h69, 8'h0E, 8'hA7};
    logic       pols[3] = '{1'b0, 1'b1, 1'b0};
    logic       phas[3] = '{1'b1, 1'b0, 1'b1};
    int cyc;
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      issue(txs[i], 1'b1, 1'b0, pols[i], phas[i], (i == 2) ? 1'b1 : 1'b0, sws[i]);
      wait_done(cyc);
      total++; if (done !== 1'b1 || cyc + 1 != 77) begin bad++; $display("FAIL b2b_latency%0d got %0d want 77", i, cyc + 1); end
      e = exp_rx.pop_front();
      total++; if (rx_data !== e) begin bad++; $display("FAIL b2b_rx%0d got %h want %h", i, rx_data, e); end
      e = exp_tx.pop_front();
      total++; if (slv_cap !== e) begin bad++; $display("FAIL b2b_mosi%0d got %h want %h", i, slv_cap, e); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    logic [7:0] e;
    issue(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA);
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    #1;
    total++; if (spi_cs_n !== 2'b11) begin bad++; $display("FAIL rst_mid_cs got %b want 11", spi_cs_n); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rx got %h want 00", rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    exp_rx.delete();
    exp_tx.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_done got %0d want 0", seen); end
    issue(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96);
    wait_done(cyc);
    total++; if (done !== 1'b1 || cyc + 1 != 77) begin bad++; $display("FAIL rst_after_latency got %0d want 77", cyc + 1); end
    e = exp_rx.pop_front();
    total++; if (rx_data !== e) begin bad++; $display("FAIL rst_after_rx got %h want %h", rx_data, e); end
    e = exp_tx.pop_front();
    total++; if (slv_cap !== e) begin bad++; $display("FAIL rst_after_mosi got %h want %h", slv_cap, e); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_lsb_first();
    test_flash_id();
    test_ignore_switch();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
